ahb3lite_req_scheduler: RTL and testbench
=========================================

Name: ahb3lite_req_scheduler

Overview:
Multi-requester scheduler in front of the AHB3-Lite master adapter. It arbitrates NREQ simple requesters (e.g. instruction fetch and load/store) and sequences one granted transaction at a time onto the adapter's peri_* request interface. Each transaction is SINGLE or a 4/8/16/INCR burst: it drives NONSEQ then SEQ, counts accepted beats, and routes per-beat data and response back to the owner. The grant is held until the last data phase completes.

Parameters:
NREQ, 2, number of requesters (2..4); index 0 is highest priority on a tie after reset.
RR_EN, 1, 1 = round-robin priority rotation after each completed transaction; 0 = fixed priority (index 0 highest).

Ports:
HCLK  in  1  bus clock
HRESETn  in  1  reset; asynchronous and active-low
req_valid  in  NREQ  requester i holds high from transaction request until its req_done
req_addr  in  NREQ*32  burst base address; stable while req_valid
req_wdata  in  NREQ*32  write data of the current beat; advanced on req_beat
req_wmask  in  NREQ*4  write strobes; 0000 = read
req_burst  in  NREQ*3  HBURST code
req_len  in  NREQ*4  beats-1 for INCR (001); ignored otherwise
req_beat  out  NREQ  1-cycle pulse: address phase of one beat accepted
rsp_valid  out  NREQ  1-cycle pulse: data phase of one beat completed
rsp_rdata  out  32  read data, valid with rsp_valid
rsp_err  out  1  error flag, valid with rsp_valid
req_done  out  NREQ  1-cycle pulse: transaction finished (normally or by error)
peri_addr / peri_wdata  out  32 each  to adapter
peri_wmask  out  4  to adapter
peri_wen / peri_ren  out  1 each  to adapter
peri_burst  out  3  to adapter
peri_htrans  out  2  to adapter
peri_rdata  in  32  from adapter
HREADY  in  1  bus ready
HRESP  in  1  bus error response

Behaviour:
- Reset values: all outputs 0; peri_htrans = IDLE; state IDLE; grant none; rr pointer 0.
- Reset mid-transaction: immediate abort to IDLE; no req_done and no rsp.
- Burst length: 000 → 1; 010/011 → 4; 100/101 → 8; 110/111 → 16; 001 → req_len+1.
- beats_left is a 5-bit counter loaded with length-1 at grant.
- States:
  - IDLE: peri_htrans = IDLE, peri_wen = peri_ren = 0. If any req_valid, latch grant g via arbiter, latch addr/wmask/burst/length, go to NSEQ.
  - NSEQ: peri_htrans = NONSEQ. On HREADY: pulse req_beat[g] and set dpend. If beats_left == 0 go to LAST, else decrement and go to SEQ.
  - SEQ: peri_htrans = SEQ. On HREADY: pulse req_beat[g]. If beats_left == 0 go to LAST, else decrement.
  - LAST: peri_htrans = IDLE. Wait for HREADY (final data phase), pulse req_done[g], go to IDLE.
  - ERR: peri_htrans = IDLE. On HREADY, pulse rsp_valid[g] with rsp_err = 1 and req_done[g], go to IDLE.
- peri_addr holds the burst base for the whole transaction; the adapter forms beat addresses.
- peri_wdata = req_wdata[g], combinational, so the adapter captures the beat's data during its address phase.
- peri_wen = (wmask != 0), peri_ren = (wmask == 0); both held from NSEQ through LAST/ERR, 0 otherwise.
- rsp_valid[g] = HREADY & dpend & !HRESP; rsp_rdata = peri_rdata.
- dpend clears in the cycle after the final data phase.
- Error handling: HRESP = 1 with HREADY = 0 in NSEQ/SEQ/LAST → drive IDLE next cycle (remaining beats cancelled) and go to ERR.
- Minimum 1 IDLE cycle between transactions; NONSEQ of a new grant appears 1 cycle after IDLE sees req_valid.
- Arbitration: only in IDLE. With RR_EN, the pointer moves to g+1 mod NREQ at req_done. A req_valid drop before req_done is a protocol violation; the scheduler completes the burst anyway.
- HTRANS BUSY is never generated.
- Wait states: HREADY low stalls both address and data phases; beats_left and outputs hold.

Decomposition:
- Shared package ahb3lite_pkg: HTRANS_* constants, HBURST_* encodings, f_burst_len function, FSM state encodings.
- Sub-module ahb_rr_arbiter (NREQ-wide req vector + pointer → one-hot grant + index).

Test Plan:
- Single read, req0 addr 0x100, HREADY = 1 → NONSEQ at cycle 1, req_beat[0] at cycle 1, rsp_valid[0] with rdata at cycle 2, req_done[0] at cycle 2.
- INCR4 write, req1 wmask 1111, data D0..D3 → NONSEQ + 3×SEQ with peri_addr held 0x200, four req_beat[1] pulses, four rsp_valid, req_done[1] after the fourth data phase.
- req0 and req1 both pending with RR_EN = 1 → grants alternate 0,1,0,1; with RR_EN = 0 → req0 always wins while held.
- INCR8 with HREADY low 2 cycles on beat 3 → htrans/peri_addr/beats_left frozen; still exactly 8 beats and 8 rsp_valid.
- HRESP two-cycle error on beat 2 of INCR16 → htrans = IDLE next cycle, one rsp_valid with rsp_err = 1, req_done, no further beats.
- HRESETn low mid-INCR4 → all outputs 0 asynchronously; after release, a new req0 starts cleanly with NONSEQ.

Source files
------------

// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-Lite encodings, burst-length decode and scheduler FSM states.
// Pure declarations: no latency, no flow control.
package ahb3lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_NSEQ,
        ST_SEQ,
        ST_LAST,
        ST_ERR
    } state_t;

    // Number of beats (1..16); len only matters for undefined-length INCR.
    function automatic logic [4:0] f_burst_len(input logic [2:0] burst, input logic [3:0] len);
        logic [4:0] n;
        case (burst)
            HBURST_SINGLE:                n = 5'd1;
            HBURST_INCR:                  n = {1'b0, len} + 5'd1;
            HBURST_WRAP4,  HBURST_INCR4:  n = 5'd4;
            HBURST_WRAP8,  HBURST_INCR8:  n = 5'd8;
            HBURST_WRAP16, HBURST_INCR16: n = 5'd16;
            default:                      n = 5'd1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/ahb_rr_arbiter.sv
// Rotating-priority arbiter: the requester at ptr has highest priority, then ptr+1, ...
// Purely combinational, zero latency; no flow control of its own.
module ahb_rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx
);

    always_comb begin
        int j;
        j   = 0;
        gnt = '0;
        idx = '0;
        // Walk from lowest to highest priority so the highest-priority hit overwrites.
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % NREQ;
            if (req[j]) begin
                gnt    = '0;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/ahb3lite_req_scheduler.sv
// Arbitrates NREQ requesters and sequences one NONSEQ/SEQ burst at a time to the adapter.
// NONSEQ one cycle after IDLE sees a request; HREADY low stalls address and data phases.
module ahb3lite_req_scheduler
    import ahb3lite_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int RR_EN = 1
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*32-1:0] req_addr,
    input  logic [NREQ*32-1:0] req_wdata,
    input  logic [NREQ*4-1:0]  req_wmask,
    input  logic [NREQ*3-1:0]  req_burst,
    input  logic [NREQ*4-1:0]  req_len,
    output logic [NREQ-1:0]    req_beat,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [31:0]        rsp_rdata,
    output logic               rsp_err,
    output logic [NREQ-1:0]    req_done,
    output logic [31:0]        peri_addr,
    output logic [31:0]        peri_wdata,
    output logic [3:0]         peri_wmask,
    output logic               peri_wen,
    output logic               peri_ren,
    output logic [2:0]         peri_burst,
    output logic [1:0]         peri_htrans,
    input  logic [31:0]        peri_rdata,
    input  logic               HREADY,
    input  logic               HRESP
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t          state_q, state_d;
    logic [IW-1:0]   g_q, ptr_q, ptr_next, arb_idx;
    logic [NREQ-1:0] g_oh_q, arb_gnt;
    logic [31:0]     addr_q;
    logic [3:0]      wmask_q;
    logic [2:0]      burst_q;
    logic [4:0]      left_q;
    logic            dpend_q;
    logic            busy, ld, dec, beat, done, rsp_v, rsp_e;
    logic [1:0]      htrans;

    ahb_rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        htrans  = HTRANS_IDLE;
        ld      = 1'b0;
        dec     = 1'b0;
        beat    = 1'b0;
        done    = 1'b0;
        rsp_v   = 1'b0;
        rsp_e   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    ld      = 1'b1;
                    state_d = ST_NSEQ;
                end
            end
            ST_NSEQ, ST_SEQ: begin
                htrans = (state_q == ST_NSEQ) ? HTRANS_NONSEQ : HTRANS_SEQ;
                rsp_v  = HREADY & dpend_q & ~HRESP;
                if (HREADY) begin
                    beat = 1'b1;
                    if (left_q == 5'd0) begin
                        state_d = ST_LAST;
                    end else begin
                        dec     = 1'b1;
                        state_d = ST_SEQ;
                    end
                end else if (HRESP) begin
                    state_d = ST_ERR;
                end
            end
            ST_LAST: begin
                rsp_v = HREADY & dpend_q & ~HRESP;
                if (HREADY) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end else if (HRESP) begin
                    state_d = ST_ERR;
                end
            end
            ST_ERR: begin
                // Second cycle of the error response: report it and drop the rest of the burst.
                if (HREADY) begin
                    rsp_v   = 1'b1;
                    rsp_e   = 1'b1;
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        if (RR_EN == 0)                  ptr_next = '0;
        else if (g_q == IW'(NREQ - 1))   ptr_next = '0;
        else                             ptr_next = g_q + 1'b1;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            g_q     <= '0;
            g_oh_q  <= '0;
            addr_q  <= '0;
            wmask_q <= '0;
            burst_q <= '0;
            left_q  <= '0;
            dpend_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            if (ld) begin
                g_q     <= arb_idx;
                g_oh_q  <= arb_gnt;
                addr_q  <= req_addr[32*arb_idx +: 32];
                wmask_q <= req_wmask[4*arb_idx +: 4];
                burst_q <= req_burst[3*arb_idx +: 3];
                left_q  <= f_burst_len(req_burst[3*arb_idx +: 3], req_len[4*arb_idx +: 4]) - 5'd1;
            end else if (dec) begin
                left_q  <= left_q - 5'd1;
            end
            if (beat)      dpend_q <= 1'b1;
            else if (done) dpend_q <= 1'b0;
            if (done)      ptr_q   <= ptr_next;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign req_beat    = beat  ? g_oh_q : '0;
    assign rsp_valid   = rsp_v ? g_oh_q : '0;
    assign req_done    = done  ? g_oh_q : '0;
    assign rsp_err     = rsp_e;
    assign rsp_rdata   = busy ? peri_rdata : '0;
    assign peri_htrans = htrans;
    assign peri_addr   = busy ? addr_q : '0;
    assign peri_wdata  = busy ? req_wdata[32*g_q +: 32] : '0;
    assign peri_wmask  = busy ? wmask_q : '0;
    assign peri_burst  = busy ? burst_q : '0;
    assign peri_wen    = busy & (|wmask_q);
    assign peri_ren    = busy & ~(|wmask_q);

endmodule

// File: tb/tb_ahb3lite_req_scheduler.sv
// Bench for ahb3lite_req_scheduler: transaction table driven through a scoreboard,
// plus arbitration and mid-burst reset sequences.
module tb_ahb3lite_req_scheduler;
    import ahb3lite_pkg::*;

    localparam int NREQ = 2;

    logic              HCLK = 1'b0;
    logic              HRESETn = 1'b0;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ*32-1:0] req_addr = '0, req_wdata = '0;
    logic [NREQ*4-1:0]  req_wmask = '0, req_len = '0;
    logic [NREQ*3-1:0]  req_burst = '0;
    logic [31:0]        peri_rdata = '0;
    logic               HREADY = 1'b1, HRESP = 1'b0;

    logic [NREQ-1:0] req_beat, rsp_valid, req_done;
    logic [31:0]     rsp_rdata, peri_addr, peri_wdata;
    logic            rsp_err, peri_wen, peri_ren;
    logic [3:0]      peri_wmask;
    logic [2:0]      peri_burst;
    logic [1:0]      peri_htrans;

    logic [NREQ-1:0] req_beat_b, rsp_valid_b, req_done_b;
    logic [31:0]     rsp_rdata_b, peri_addr_b, peri_wdata_b;
    logic            rsp_err_b, peri_wen_b, peri_ren_b;
    logic [3:0]      peri_wmask_b;
    logic [2:0]      peri_burst_b;
    logic [1:0]      peri_htrans_b;

    ahb3lite_req_scheduler #(.NREQ(NREQ), .RR_EN(1)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .req_valid(req_valid), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wmask(req_wmask), .req_burst(req_burst), .req_len(req_len),
        .req_beat(req_beat), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .req_done(req_done), .peri_addr(peri_addr), .peri_wdata(peri_wdata),
        .peri_wmask(peri_wmask), .peri_wen(peri_wen), .peri_ren(peri_ren),
        .peri_burst(peri_burst), .peri_htrans(peri_htrans), .peri_rdata(peri_rdata),
        .HREADY(HREADY), .HRESP(HRESP)
    );

    // Fixed-priority instance sharing all inputs; only its grants are inspected.
    ahb3lite_req_scheduler #(.NREQ(NREQ), .RR_EN(0)) dut_fixed (
        .HCLK(HCLK), .HRESETn(HRESETn), .req_valid(req_valid), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wmask(req_wmask), .req_burst(req_burst), .req_len(req_len),
        .req_beat(req_beat_b), .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b),
        .req_done(req_done_b), .peri_addr(peri_addr_b), .peri_wdata(peri_wdata_b),
        .peri_wmask(peri_wmask_b), .peri_wen(peri_wen_b), .peri_ren(peri_ren_b),
        .peri_burst(peri_burst_b), .peri_htrans(peri_htrans_b), .peri_rdata(peri_rdata),
        .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        int          idx;
        logic [31:0] addr;
        logic [3:0]  wmask;
        logic [2:0]  burst;
        logic [3:0]  len;
        int          stall_t;
        int          stall_n;
        int          err_t;
        int          nlen;
        int          exp_beats;
        int          exp_rsps;
        int          exp_errs;
    } txn_t;

    typedef struct {
        int          idx;
        logic [1:0]  ht;
        logic [31:0] dat;
        logic        err;
    } ev_t;

    ev_t  beat_q[$], rsp_q[$], done_q[$];
    txn_t tbl[8];
    int   nchk = 0, nerr = 0, nbeat = 0, nrsp = 0, nerrsp = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [NREQ-1:0] oh(input int i);
        logic [NREQ-1:0] r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    function automatic ev_t mk_ev(input int i, input logic [1:0] ht, input logic [31:0] d, input logic e);
        ev_t v;
        v.idx = i; v.ht = ht; v.dat = d; v.err = e;
        return v;
    endfunction

    function automatic logic [31:0] wd(input int i, input int b);
        return 32'hD000_0000 | 32'(i << 8) | 32'(b);
    endfunction

    // Scoreboard: each cycle's expected pulses are queued before this edge samples them.
    always @(negedge HCLK) begin
        ev_t e;
        if (req_beat != '0) nbeat++;
        if (rsp_valid != '0) nrsp++;
        if (rsp_valid != '0 && rsp_err) nerrsp++;
        if (req_beat != '0 || beat_q.size() != 0) begin
            if (beat_q.size() == 0) chk("unexpected_beat", 64'(req_beat), 64'd0);
            else begin
                e = beat_q.pop_front();
                chk("beat_vec", 64'(req_beat), 64'(oh(e.idx)));
                chk("beat_htrans", 64'(peri_htrans), 64'(e.ht));
                chk("beat_wdata", 64'(peri_wdata), 64'(e.dat));
            end
        end
        if (rsp_valid != '0 || rsp_q.size() != 0) begin
            if (rsp_q.size() == 0) chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
            else begin
                e = rsp_q.pop_front();
                chk("rsp_vec", 64'(rsp_valid), 64'(oh(e.idx)));
                chk("rsp_rdata", 64'(rsp_rdata), 64'(e.dat));
                chk("rsp_err", 64'(rsp_err), 64'(e.err));
            end
        end
        if (req_done != '0 || done_q.size() != 0) begin
            if (done_q.size() == 0) chk("unexpected_done", 64'(req_done), 64'd0);
            else begin
                e = done_q.pop_front();
                chk("done_vec", 64'(req_done), 64'(oh(e.idx)));
            end
        end
    end

    // Drives one transaction with a bus-side model of the AHB address/data pipeline.
    task automatic run_txn(input txn_t r);
        int rc, t, b0, r0, e0;
        bit fin, err_next, acc, rdy, hr;
        logic [31:0] rd;
        logic [1:0]  eht;
        rc = 0; t = 0; fin = 0; err_next = 0;
        b0 = nbeat; r0 = nrsp; e0 = nerrsp;
        req_valid[r.idx]            = 1'b1;
        req_addr[32*r.idx +: 32]    = r.addr;
        req_wmask[4*r.idx +: 4]     = r.wmask;
        req_burst[3*r.idx +: 3]     = r.burst;
        req_len[4*r.idx +: 4]       = r.len;
        req_wdata[32*r.idx +: 32]   = wd(r.idx, 0);
        HREADY = 1'b1; HRESP = 1'b0;
        @(posedge HCLK); #1;
        while (!fin && t < 100) begin
            rdy = !(t >= r.stall_t && t < r.stall_t + r.stall_n);
            hr  = 1'b0;
            if (err_next) begin rdy = 1'b1; hr = 1'b1; end
            else if (t == r.err_t) begin rdy = 1'b0; hr = 1'b1; end
            rd = 32'h5EED_0000 | 32'(t << 4) | 32'(r.idx);
            HREADY = rdy; HRESP = hr; peri_rdata = rd;
            eht = (rc == 0) ? HTRANS_NONSEQ : (rc < r.nlen) ? HTRANS_SEQ : HTRANS_IDLE;
            acc = 1'b0;
            if (err_next) begin
                eht = HTRANS_IDLE;
                rsp_q.push_back(mk_ev(r.idx, 2'b00, rd, 1'b1));
                done_q.push_back(mk_ev(r.idx, 2'b00, 32'd0, 1'b0));
                fin = 1'b1;
            end else if (hr) begin
                err_next = 1'b1;
            end else if (rdy) begin
                if (rc < r.nlen) begin
                    beat_q.push_back(mk_ev(r.idx, eht, wd(r.idx, rc), 1'b0));
                    acc = 1'b1;
                end
                if (rc >= 1) rsp_q.push_back(mk_ev(r.idx, 2'b00, rd, 1'b0));
                if (rc == r.nlen) begin
                    done_q.push_back(mk_ev(r.idx, 2'b00, 32'd0, 1'b0));
                    fin = 1'b1;
                end
                rc++;
            end
            @(negedge HCLK);
            chk("htrans", 64'(peri_htrans), 64'(eht));
            chk("peri_addr", 64'(peri_addr), 64'(r.addr));
            chk("peri_burst", 64'(peri_burst), 64'(r.burst));
            chk("peri_wen", 64'(peri_wen), 64'(r.wmask != 4'h0));
            chk("peri_ren", 64'(peri_ren), 64'(r.wmask == 4'h0));
            @(posedge HCLK); #1;
            if (acc) req_wdata[32*r.idx +: 32] = wd(r.idx, rc);
            t++;
        end
        req_valid[r.idx] = 1'b0;
        HREADY = 1'b1; HRESP = 1'b0;
        chk("txn_finished", 64'(fin), 64'd1);
        chk("n_beats", 64'(nbeat - b0), 64'(r.exp_beats));
        chk("n_rsps", 64'(nrsp - r0), 64'(r.exp_rsps));
        chk("n_err_rsps", 64'(nerrsp - e0), 64'(r.exp_errs));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (t=%0t)", $time);
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int g;
        //          idx addr          wmask  burst           len  st_t st_n err  nlen beats rsps errs
        tbl[0] = '{0, 32'h0000_0100, 4'h0, HBURST_SINGLE, 4'd0, -1,  0,  -1,  1,   1,   1,   0};
        tbl[1] = '{1, 32'h0000_0200, 4'hF, HBURST_INCR,   4'd3, -1,  0,  -1,  4,   4,   4,   0};
        tbl[2] = '{0, 32'h0000_0500, 4'h0, HBURST_INCR8,  4'd0,  3,  2,  -1,  8,   8,   8,   0};
        tbl[3] = '{1, 32'h0000_0700, 4'h0, HBURST_INCR16, 4'd0, -1,  0,   2, 16,   2,   2,   1};
        tbl[4] = '{0, 32'h0000_0800, 4'h3, HBURST_WRAP4,  4'd9, -1,  0,  -1,  4,   4,   4,   0};
        tbl[5] = '{1, 32'h0000_0900, 4'h8, HBURST_SINGLE, 4'd7,  0,  1,  -1,  1,   1,   1,   0};
        tbl[6] = '{1, 32'h0000_0A00, 4'h1, HBURST_INCR,   4'd0, -1,  0,  -1,  1,   1,   1,   0};
        tbl[7] = '{0, 32'h0000_0100, 4'h0, HBURST_SINGLE, 4'd0, -1,  0,  -1,  1,   1,   1,   0};

        peri_rdata = 32'hFFFF_0000;
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        chk("reset_outs", 64'(|{req_beat, rsp_valid, rsp_rdata, rsp_err, req_done, peri_addr,
                               peri_wdata, peri_wmask, peri_wen, peri_ren, peri_burst, peri_htrans}), 64'd0);
        chk("reset_htrans", 64'(peri_htrans), 64'(HTRANS_IDLE));
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        @(posedge HCLK); #1;

        for (int i = 0; i < 7; i++) run_txn(tbl[i]);

        // Both requesters held: round-robin alternates, fixed priority keeps granting 0.
        req_valid = 2'b11;
        req_addr  = {32'h0000_0400, 32'h0000_0300};
        req_wmask = '0; req_burst = '0; req_len = '0;
        req_wdata = {32'hB1B1_0001, 32'hA0A0_0000};
        for (int k = 0; k < 4; k++) begin
            g = k % 2;
            @(posedge HCLK); #1;
            beat_q.push_back(mk_ev(g, HTRANS_NONSEQ, req_wdata[32*g +: 32], 1'b0));
            @(negedge HCLK);
            chk("rr_addr", 64'(peri_addr), (g == 0) ? 64'h300 : 64'h400);
            chk("fixed_beat", 64'(req_beat_b), 64'd1);
            @(posedge HCLK); #1;
            rd = 32'hAB00_0000 | 32'(k);
            peri_rdata = rd;
            rsp_q.push_back(mk_ev(g, 2'b00, rd, 1'b0));
            done_q.push_back(mk_ev(g, 2'b00, 32'd0, 1'b0));
            @(negedge HCLK);
            chk("fixed_done", 64'(req_done_b), 64'd1);
            chk("fixed_rdata", 64'(rsp_rdata_b), 64'(rd));
            @(posedge HCLK); #1;
        end
        req_valid = '0;

        // Reset in the middle of an INCR4 write.
        @(posedge HCLK); #1;
        req_valid[0]      = 1'b1;
        req_addr[31:0]    = 32'h0000_0600;
        req_wmask[3:0]    = 4'hF;
        req_burst[2:0]    = HBURST_INCR4;
        req_wdata[31:0]   = wd(0, 0);
        @(posedge HCLK); #1;
        beat_q.push_back(mk_ev(0, HTRANS_NONSEQ, wd(0, 0), 1'b0));
        @(negedge HCLK);
        @(posedge HCLK); #1;
        req_wdata[31:0] = wd(0, 1);
        peri_rdata = 32'h1234_5678;
        beat_q.push_back(mk_ev(0, HTRANS_SEQ, wd(0, 1), 1'b0));
        rsp_q.push_back(mk_ev(0, 2'b00, 32'h1234_5678, 1'b0));
        @(negedge HCLK);
        @(posedge HCLK); #1;
        req_wdata[31:0] = wd(0, 2);
        #2;
        HRESETn = 1'b0;
        #1;
        chk("midrst_outs", 64'(|{req_beat, rsp_valid, rsp_rdata, rsp_err, req_done, peri_addr,
                                peri_wdata, peri_wmask, peri_wen, peri_ren, peri_burst, peri_htrans}), 64'd0);
        chk("midrst_htrans", 64'(peri_htrans), 64'(HTRANS_IDLE));
        req_valid = '0;
        @(posedge HCLK); #1;
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        @(posedge HCLK); #1;
        run_txn(tbl[7]);

        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        chk("beat_q_empty", 64'(beat_q.size()), 64'd0);
        chk("rsp_q_empty", 64'(rsp_q.size()), 64'd0);
        chk("done_q_empty", 64'(done_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
